// File: rtl/debounce_scan_ctrl.sv
// Time-shared debouncer: one prescaler, a scan FSM visiting each channel per
// tick, and round-robin press/release events on a valid/ready port.
//
// Ports:
//   clk, rst (async, active-low)
//   raw[N]        : undebounced inputs (synchronized internally)
//   enable        : 1 = prescaler runs and ticks are issued
//   clr_overflow  : pulse, clears the sticky overflow flag
//   state[N]      : debounced levels
//   evt_valid/evt_ready/evt_chan/evt_edge : event handshake (edge 1 = press)
//   overflow      : sticky, a pending event was overwritten before accept
module debounce_scan_ctrl #(
  parameter int          N            = 4,
  parameter int          CHAN_W       = 2,
  parameter logic [19:0] TICK_DIV     = 20'd49999,
  parameter logic [3:0]  STABLE_TICKS = 4'd10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      raw,
  input  logic              enable,
  input  logic              clr_overflow,
  output logic [N-1:0]      state,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CHAN_W-1:0] evt_chan,
  output logic              evt_edge,
  output logic              overflow
);

  localparam int CNT_W =
    (STABLE_TICKS > 4'd1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(STABLE_TICKS - 4'd1);
  localparam logic [CHAN_W-1:0] LAST = CHAN_W'(N - 1);

  typedef enum logic {IDLE, SCAN} st_e;

  function automatic logic [CHAN_W-1:0] wrap_add(
    input logic [CHAN_W-1:0] a,
    input int                k
  );
    int s;
    s = int'(a) + k;
    if (s >= N) s = s - N;
    return CHAN_W'(s);
  endfunction

  logic [N-1:0]      s1_q, s2_q;
  logic [19:0]       presc_q, presc_d;
  logic              tick;
  st_e               st_q, st_d;
  logic [CHAN_W-1:0] idx_q, idx_d;
  logic              visit;
  logic [CNT_W-1:0]  cnt_q [N];
  logic [CNT_W-1:0]  cnt_d [N];
  logic [N-1:0]      state_q, state_d;
  logic [N-1:0]      pend_q, pend_d;
  logic [N-1:0]      pedge_q, pedge_d;
  logic              repend_q, repend_d;
  logic              acc;
  logic              accept;
  logic              ov_q, ov_d;
  logic              evt_valid_q, evt_valid_d;
  logic [CHAN_W-1:0] evt_chan_q, evt_chan_d;
  logic              evt_edge_q, evt_edge_d;
  logic [CHAN_W-1:0] rr_q, rr_d;
  logic [CHAN_W-1:0] sel;
  logic              sel_hit;

  always_comb begin
    tick    = enable && (presc_q == TICK_DIV);
    presc_d = presc_q + 20'd1;
    if (!enable || tick) presc_d = '0;
  end

  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    visit = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (tick) begin
          st_d  = SCAN;
          idx_d = '0;
        end
      end
      SCAN: begin
        visit = 1'b1;
        if (idx_q == LAST) begin
          st_d  = IDLE;
          idx_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    sel     = '0;
    sel_hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!sel_hit && pend_q[wrap_add(rr_q, k)]) begin
        sel_hit = 1'b1;
        sel     = wrap_add(rr_q, k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    pedge_d  = pedge_q;
    repend_d = repend_q;
    ov_d     = ov_q;
    acc      = 1'b0;
    for (int i = 0; i < N; i++) cnt_d[i] = cnt_q[i];
    accept = evt_valid_q & evt_ready;
    // repend marks that the presented channel was re-armed after latching,
    // so its pend bit must survive the accept and re-present the new edge
    if (accept) begin
      if (!repend_q) pend_d[evt_chan_q] = 1'b0;
      repend_d = 1'b0;
    end
    if (visit) begin
      if (s2_q[idx_q] == state_q[idx_q]) begin
        cnt_d[idx_q] = '0;
      end else if (cnt_q[idx_q] == CNT_MAX) begin
        acc            = 1'b1;
        state_d[idx_q] = s2_q[idx_q];
        cnt_d[idx_q]   = '0;
        pend_d[idx_q]  = 1'b1;
        pedge_d[idx_q] = s2_q[idx_q];
      end else begin
        cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
      end
    end
    if (acc && !accept && (
          (evt_valid_q && evt_chan_q == idx_q) ||
          (!evt_valid_q && sel_hit && sel == idx_q)))
      repend_d = 1'b1;
    if (clr_overflow) ov_d = 1'b0;
    if (acc && pend_q[idx_q] &&
        !(accept && evt_chan_q == idx_q))
      ov_d = 1'b1;
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_chan_d  = evt_chan_q;
    evt_edge_d  = evt_edge_q;
    rr_d        = rr_q;
    if (accept) begin
      evt_valid_d = 1'b0;
      rr_d        = wrap_add(evt_chan_q, 1);
    end else if (!evt_valid_q && sel_hit) begin
      evt_valid_d = 1'b1;
      evt_chan_d  = sel;
      evt_edge_d  = pedge_q[sel];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      presc_q     <= '0;
      st_q        <= IDLE;
      idx_q       <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      state_q     <= '0;
      pend_q      <= '0;
      pedge_q     <= '0;
      repend_q    <= 1'b0;
      ov_q        <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_chan_q  <= '0;
      evt_edge_q  <= 1'b0;
      rr_q        <= '0;
    end else begin
      s1_q        <= raw;
      s2_q        <= s1_q;
      presc_q     <= presc_d;
      st_q        <= st_d;
      idx_q       <= idx_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      state_q     <= state_d;
      pend_q      <= pend_d;
      pedge_q     <= pedge_d;
      repend_q    <= repend_d;
      ov_q        <= ov_d;
      evt_valid_q <= evt_valid_d;
      evt_chan_q  <= evt_chan_d;
      evt_edge_q  <= evt_edge_d;
      rr_q        <= rr_d;
    end
  end

  assign state     = state_q;
  assign evt_valid = evt_valid_q;
  assign evt_chan  = evt_chan_q;
  assign evt_edge  = evt_edge_q;
  assign overflow  = ov_q;

endmodule

// File: doc/debounce_scan_ctrl.md
Name: debounce_scan_ctrl

Overview:
- Time-shared debounce controller for N push-button/switch inputs.
- One shared prescaler generates sample ticks. On each tick, a scan state machine visits every channel in turn and updates that channel's small stability counter.
- Debounced level changes become press/release events, arbitrated round-robin onto a single valid/ready event port for the front-panel logic.
- Replaces N free-running 20-bit debouncers with one prescaler and N narrow counters.

Parameters:
- N, 4, number of input channels (2..16).
- CHAN_W, 2, width of channel index; must equal clog2(N).
- TICK_DIV, 20'd49999, prescaler terminal count; one sample tick every TICK_DIV+1 clocks; constraint TICK_DIV+1 > N.
- STABLE_TICKS, 4'd10, consecutive differing samples needed to accept a new level (1..15).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- raw  input  N  undebounced inputs, asynchronous to clk
- enable  input  1  1 = scanning active
- clr_overflow  input  1  single-cycle pulse, clears overflow
- state  output  N  debounced levels
- evt_valid  output  1  event available
- evt_ready  input  1  consumer accepts event when high with evt_valid
- evt_chan  output  CHAN_W  channel of presented event
- evt_edge  output  1  1 = rise (press), 0 = fall (release)
- overflow  output  1  sticky: an event was overwritten before being consumed

Behaviour:
- Reset (rst low, async): state, evt_valid, evt_chan, evt_edge, overflow = 0. Prescaler, all channel counters, pending flags, sync flops, round-robin pointer = 0. FSM = IDLE.
- Input sync: each raw bit passes through a 2-flop synchronizer. The scan samples only the synchronized value.
- Prescaler: counts 0..TICK_DIV while enable=1 and issues tick when count==TICK_DIV, then wraps to 0. When enable=0, the prescaler is held at 0 and no ticks are issued.
- FSM states:
  - IDLE: on tick, go to SCAN with idx=0.
  - SCAN: visit channel idx, one channel per clock. After idx==N-1, return to IDLE. A full scan takes N cycles.
  - A tick arriving while in SCAN is ignored.
  - enable falling mid-scan does not abort the scan in progress.
- Channel visit for channel i:
  - sync[i]==state[i]: cnt[i] <= 0.
  - Else if cnt[i]==STABLE_TICKS-1: state[i] <= sync[i] and cnt[i] <= 0. Set pend[i]=1 and pedge[i]=sync[i]. If pend[i] was already 1 and is not being accepted this cycle, overflow <= 1.
  - Else: cnt[i] <= cnt[i]+1.
  - state[i] updates the clock after the visit.
  - Latency: a change stable across STABLE_TICKS consecutive ticks is accepted on the last of those visits.
- Event output:
  - When evt_valid=0 and any pend bit is set, the registered selector picks the first pending channel at or after rr_ptr (wrapping). Next cycle it drives evt_valid=1, evt_chan, evt_edge=pedge.
  - Payload holds stable while evt_valid=1 and evt_ready=0.
  - Accept (valid & ready): clear pend[evt_chan], set rr_ptr = evt_chan+1 (mod N), evt_valid <= 0 next cycle. Back-to-back events therefore have one idle cycle between them.
  - Same-cycle accept of channel i and a new acceptance on channel i: the new event wins; pend[i] stays 1 with the new edge, and overflow is not set.
  - pedge of a channel currently being presented may update (overwrite case). The presented evt_edge still holds its latched value until accept, after which pend[i] re-presents the new edge.
- overflow: set as above. Cleared by clr_overflow. If set and clear occur in the same cycle, set wins.
- Counter width: ceil(log2(STABLE_TICKS)) bits minimum, never wraps; the reset-to-0 rule is exclusive.

Test Plan (N=4, TICK_DIV=9, STABLE_TICKS=3):
- raw[2] 0->1 held, evt_ready=0 -> state[2]=1 after 3rd tick visit (~30 clocks + sync). evt_valid=1, evt_chan=2, evt_edge=1, held. Pulse evt_ready -> evt_valid=0 the next cycle, pend cleared.
- raw[1] high for 2 ticks then low -> state[1] stays 0, no event, cnt[1] back to 0. A subsequent 3-tick high produces exactly one event.
- raw[0] and raw[3] rise together, evt_ready=0 -> chan 0 presented first. Accept -> chan 3 presented. Then raw[0] falls and raw[3] falls, both pending with rr_ptr=0 -> chan 0, then chan 3.
- raw[1] rise accepted then fall accepted with evt_ready=0 throughout -> overflow=1. After chan1 rise is accepted, chan1 is re-presented with edge=0. clr_overflow -> overflow=0; clr and set in the same cycle -> overflow=1.
- rst low mid-SCAN with evt_valid=1 and raw[0]=1 -> all outputs 0 immediately. After release, state[0] rises after 3 ticks and a press event is issued.
- enable=0, toggle raw[3] and hold -> prescaler 0, state and events unchanged. enable=1 -> event appears after 3 ticks.
